uart_rcv: RTL and testbench

- 8N1 UART receiver. It is the receiving end of the serial command link that UART_tx drives.
- Converts the asynchronous RX line into a parallel byte with a ready flag.
- Instantiated inside Segway to take BLE commands ('g' 0x67 = go, 's' 0x73 = stop) and hand them to the auth block.
- Mid-bit sampling from a single-clock baud counter; no oversampling majority vote.

---
 rtl/uart_rcv.sv | 171 +++++++++++++++++
 tb/tb_uart_rcv.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rcv.sv
`default_nettype none
// ============================================================================
// Module      : uart_rcv
// Description : 8N1 UART receiver. RX is double-synchronised, a falling edge
//               starts a frame, and a single baud counter places one sample
//               at the centre of every bit (start, 8 data LSB first, stop).
//               A completed byte is presented on rx_data with a sticky rdy
//               flag that the consumer clears with clr_rdy.
// Options     : UART_FRAME_ERR_EN - when defined, a frame whose stop sample
//               is 0 is discarded and frm_err pulses for one clock instead
//               of setting rdy. When undefined, frm_err is tied low and the
//               stop bit is not checked.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rcv #(
    parameter int BAUD_DIV = 2604,  // clocks per bit, >= 16
    parameter int CNT_W    = 12     // baud counter width, must hold BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Half a bit from the start edge lands the first sample at the start-bit
    // centre; a full bit between later samples keeps them centred.
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       LAST_BIT = 4'd9;  // index of the stop sample

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]       bit_cnt_q,  bit_cnt_d;
    logic [8:0]       shift_q,    shift_d;
    logic [7:0]       rx_data_q,  rx_data_d;
    logic             rdy_q,      rdy_d;
    logic             rx_ff1_q, rx_ff2_q, rx_prev_q;
    logic             start_edge;

    // Two-flop synchroniser plus one history flop for edge detection; all
    // preset high so that leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1_q  <= 1'b1;
            rx_ff2_q  <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_ff1_q  <= RX;
            rx_ff2_q  <= rx_ff1_q;
            rx_prev_q <= rx_ff2_q;
        end
    end

    assign start_edge = rx_prev_q & ~rx_ff2_q;

`ifdef UART_FRAME_ERR_EN
    logic frm_err_q, frm_err_d;
`endif

    // Next-state, counters, shift register and handshake flag.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rdy_d      = rdy_q;
`ifdef UART_FRAME_ERR_EN
        frm_err_d  = 1'b0;
`endif
        // Acknowledge first so that a completion below overrides it.
        if (clr_rdy) begin
            rdy_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (start_edge) begin
                    state_d    = RECEIVE;
                    baud_cnt_d = HALF_CNT;
                    bit_cnt_d  = 4'd0;
                    rdy_d      = 1'b0;
                end
            end
            RECEIVE: begin
                if (baud_cnt_q == '0) begin
                    if ((bit_cnt_q == 4'd0) && rx_ff2_q) begin
                        // Start bit gone high by its centre: line glitch.
                        state_d = IDLE;
                    end else begin
                        shift_d    = {rx_ff2_q, shift_q[8:1]};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        baud_cnt_d = FULL_CNT;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = DONE;
                        end
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            DONE: begin
                // shift_q[8] is the stop bit, shift_q[7:0] the data byte.
                state_d    = IDLE;
                baud_cnt_d = '0;
`ifdef UART_FRAME_ERR_EN
                if (shift_q[8]) begin
                    rx_data_d = shift_q[7:0];
                    rdy_d     = 1'b1;
                end else begin
                    frm_err_d = 1'b1;
                end
`else
                rx_data_d = shift_q[7:0];
                rdy_d     = 1'b1;
`endif
            end
            default: begin
                state_d    = IDLE;
                baud_cnt_d = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 9'd0;
            rx_data_q  <= 8'd0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
        end
    end

`ifdef UART_FRAME_ERR_EN
    // One-clock framing error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_err_q <= 1'b0;
        end else begin
            frm_err_q <= frm_err_d;
        end
    end
    assign frm_err = frm_err_q;
`else
    assign frm_err = 1'b0;
`endif

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rcv.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rcv
// Description : Self-checking bench for uart_rcv. Frames are driven on RX bit
//               by bit; every frame sent is queued with its start time and a
//               per-cycle compare process matches each rdy/frm_err event to
//               the queue (byte value, latency window, handshake rules).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rcv;

    localparam int B   = 40;             // bench baud divisor (keeps runs short)
    localparam int CW  = 8;
    localparam int LAT = (19 * B) / 2;   // nominal 9.5 bit times
    localparam int LO  = LAT - 4;
    localparam int HI  = LAT + 8;

    typedef struct {
        logic [7:0] data;
        bit         bad;
        int         t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   last_start = -1000;
    int   done_cnt = 0;
    int   ferr_cnt = 0;
    int   last_lat = 0;
    bit   rand_clr = 1'b0;
    logic clr_dir = 1'b0;

    uart_rcv #(.BAUD_DIV(B), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // clr_rdy source: directed value or random pulses.
    always @(posedge clk) begin
        #2;
        clr_rdy = rand_clr ? ($urandom_range(0, 5) == 0) : clr_dir;
    end

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one 8N1 frame; bad=1 sends a 0 stop bit then idles high a bit.
    task automatic send(input logic [7:0] b, input bit bad);
        exp_t e;
        e.data = b;
        e.bad  = bad;
        e.t0   = cyc;
        q.push_back(e);
        last_start = cyc;
        RX = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(B);
        end
        RX = ~bad;
        tick(B);
        RX = 1'b1;
        if (bad) tick(B);
    endtask

    task automatic glitch(input int len);
        last_start = cyc;
        RX = 1'b0;
        tick(len);
        RX = 1'b1;
        tick(B);
    endtask

    // Per-cycle compare against the frame queue.
    logic       prev_rdy = 1'b0;
    logic       prev_clr = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] prev_data = 8'd0;

    always @(negedge clk) begin : compare
        exp_t e;
        int   lat;
        bit   done_ev;
        if (!rst_n) begin
            prev_rdy  = rdy;
            prev_data = rx_data;
            prev_clr  = 1'b0;
            prev_ferr = 1'b0;
        end else begin
            done_ev = rdy && (!prev_rdy || (rx_data != prev_data));
            if (done_ev) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_rdy", rx_data, 0);
                end else begin
                    e = q.pop_front();
                    lat = cyc - e.t0;
                    last_lat = lat;
                    done_cnt++;
                    chk(rx_data == e.data, "rx_data", rx_data, e.data);
                    chk(lat >= LO && lat <= HI, "rdy_latency", lat, LAT);
`ifdef UART_FRAME_ERR_EN
                    chk(!e.bad, "rdy_on_bad_stop", 1, 0);
`endif
                end
            end
`ifdef UART_FRAME_ERR_EN
            if (frm_err) begin
                if (prev_ferr) begin
                    chk(1'b0, "frm_err_width", 2, 1);
                end else if (q.size() == 0) begin
                    chk(1'b0, "unexpected_frm_err", 1, 0);
                end else begin
                    e = q.pop_front();
                    lat = cyc - e.t0;
                    ferr_cnt++;
                    chk(e.bad, "frm_err_on_good_stop", 1, 0);
                    chk(lat >= LO && lat <= HI, "frm_err_latency", lat, LAT);
                end
            end
`else
            chk(frm_err == 1'b0, "frm_err_tied", frm_err, 0);
`endif
            if (!rdy && prev_rdy)
                chk(prev_clr || ((cyc - last_start) <= 8), "rdy_drop", rdy, 1);
            if (rdy && prev_rdy && prev_clr && !done_ev)
                chk(1'b0, "clr_ignored", rdy, 0);
            if (!rdy && (rx_data != prev_data))
                chk(1'b0, "rx_data_change", rx_data, prev_data);
            if ((q.size() > 0) && ((cyc - q[0].t0) > HI)) begin
                chk(1'b0, "frame_missing", q[0].data, q[0].data);
                void'(q.pop_front());
            end
            prev_rdy  = rdy;
            prev_data = rx_data;
            prev_clr  = clr_rdy;
            prev_ferr = frm_err;
        end
    end

    initial begin : watchdog
        #(900000);
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int d0;
        logic [7:0] b;
        // Reset values
        tick(3);
        chk(rdy == 1'b0, "reset_rdy", rdy, 0);
        chk(rx_data == 8'h00, "reset_rx_data", rx_data, 0);
        chk(frm_err == 1'b0, "reset_frm_err", frm_err, 0);
        rst_n = 1'b1;
        tick(5);

        // Single byte
        send(8'hA5, 1'b0);
        tick(2);
        chk(rx_data == 8'hA5, "a5_data", rx_data, 8'hA5);
        chk(rdy == 1'b1, "a5_rdy", rdy, 1);
        chk(done_cnt == 1, "a5_count", done_cnt, 1);
        chk(last_lat >= LO && last_lat <= HI, "a5_latency", last_lat, LAT);

        // Back-to-back, no acknowledge between
        send(8'h67, 1'b0);
        chk(rx_data == 8'h67, "b2b_first", rx_data, 8'h67);
        send(8'h73, 1'b0);
        tick(2);
        chk(rx_data == 8'h73, "b2b_second", rx_data, 8'h73);
        chk(rdy == 1'b1, "b2b_rdy", rdy, 1);

        // Acknowledge clears rdy next clock, data held
        send(8'h67, 1'b0);
        tick(4);
        clr_dir = 1'b1;
        tick(1);
        clr_dir = 1'b0;
        chk(rdy == 1'b0, "clr_rdy", rdy, 0);
        chk(rx_data == 8'h67, "clr_hold", rx_data, 8'h67);

        // Acknowledge held across completion: set must win
        d0 = done_cnt;
        fork
            send(8'h67, 1'b0);
            begin
                tick(LO - 2);
                clr_dir = 1'b1;
                tick(HI - LO + 6);
                clr_dir = 1'b0;
            end
        join
        chk(done_cnt == d0 + 1, "set_priority", done_cnt, d0 + 1);

        // Short low glitch is not a frame; next byte still fine
        d0 = done_cnt;
        glitch(12);
        chk(done_cnt == d0, "glitch_no_rdy", done_cnt, d0);
        send(8'h3C, 1'b0);
        tick(2);
        chk(rx_data == 8'h3C, "after_glitch", rx_data, 8'h3C);

        // Stop bit = 0
        send(8'h55, 1'b1);
`ifdef UART_FRAME_ERR_EN
        chk(ferr_cnt == 1, "bad_stop_frm_err", ferr_cnt, 1);
        chk(rdy == 1'b0, "bad_stop_rdy", rdy, 0);
        chk(rx_data == 8'h3C, "bad_stop_data", rx_data, 8'h3C);
`else
        chk(rdy == 1'b1, "bad_stop_rdy", rdy, 1);
        chk(rx_data == 8'h55, "bad_stop_data", rx_data, 8'h55);
`endif

        // Reset during data bit 4
        fork
            send(8'hFF, 1'b0);
            begin
                tick(5 * B + B / 2);
                rst_n = 1'b0;
                #1;
                chk(rdy == 1'b0, "midreset_rdy", rdy, 0);
                chk(rx_data == 8'h00, "midreset_data", rx_data, 0);
                q.delete();
                tick(3);
                rst_n = 1'b1;
            end
        join
        tick(B);
        send(8'h12, 1'b0);
        tick(2);
        chk(rx_data == 8'h12, "after_reset", rx_data, 8'h12);

        // Random traffic
        rand_clr = 1'b1;
        for (int n = 0; n < 40; n++) begin
            b = 8'($urandom);
            case ($urandom_range(0, 5))
                0: ;                                     // back-to-back
                1: glitch($urandom_range(1, B / 2 - 6));
                default: tick($urandom_range(1, 2 * B));
            endcase
            send(b, ($urandom_range(0, 7) == 0));
        end
        rand_clr = 1'b0;

        for (int i = 0; (i < 2 * HI) && (q.size() > 0); i++) tick(1);
        chk(q.size() == 0, "queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
